// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared widths, defaults and temperature FSM states
package sensor_pkg;

    localparam int TEMP_W = 7;
    localparam int SUM_W  = 9;
    localparam int CNT_W  = 3;

    localparam logic [TEMP_W-1:0] TEMP_MAX_DEF = 7'd100;
    localparam logic [TEMP_W-1:0] TEMP_RST_DEF = 7'd25;

    typedef enum logic {
        T_EMPTY,
        T_RUN
    } temp_state_t;

endpackage

// File: rtl/debounce_cell.sv
// rtl/debounce_cell.sv - two-flop synchroniser plus counted debounce, optional fast set
module debounce_cell
    import sensor_pkg::*;
#(
    parameter int DEB_CYCLES = 4,
    parameter bit FAST_SET   = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic out
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            out   <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            if (sync2 == out) begin
                cnt <= '0;
            end else if (FAST_SET && sync2) begin
                // Safety path: an alarm is passed on as soon as it is synchronised.
                out <= 1'b1;
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                out <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - debounced door/window/alarm levels and 4-sample temperature average
module sensor_conditioner
    import sensor_pkg::*;
#(
    parameter int                DEB_CYCLES = 4,
    parameter logic [TEMP_W-1:0] TEMP_MAX   = TEMP_MAX_DEF,
    parameter logic [TEMP_W-1:0] TEMP_RST   = TEMP_RST_DEF
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              raw_fd,
    input  logic              raw_rd,
    input  logic              raw_w,
    input  logic              raw_fa,
    input  logic [TEMP_W-1:0] adc_temp,
    input  logic              adc_valid,
    output logic              SFD,
    output logic              SRD,
    output logic              SW,
    output logic              SFA,
    output logic [TEMP_W-1:0] ST,
    output logic              temp_fault
);

    debounce_cell #(.DEB_CYCLES(DEB_CYCLES), .FAST_SET(1'b0)) u_fd (.clk(Clk), .rst(Rst), .raw(raw_fd), .out(SFD));
    debounce_cell #(.DEB_CYCLES(DEB_CYCLES), .FAST_SET(1'b0)) u_rd (.clk(Clk), .rst(Rst), .raw(raw_rd), .out(SRD));
    debounce_cell #(.DEB_CYCLES(DEB_CYCLES), .FAST_SET(1'b0)) u_w  (.clk(Clk), .rst(Rst), .raw(raw_w),  .out(SW));
    debounce_cell #(.DEB_CYCLES(DEB_CYCLES), .FAST_SET(1'b1)) u_fa (.clk(Clk), .rst(Rst), .raw(raw_fa), .out(SFA));

    temp_state_t       state_q, state_d;
    logic [TEMP_W-1:0] w_q [4];
    logic [TEMP_W-1:0] w_d [4];
    logic [SUM_W-1:0]  sum_q, sum_d;
    logic [TEMP_W-1:0] st_q, st_d;
    logic              fault_q, fault_d;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= T_EMPTY;
            for (int i = 0; i < 4; i++) w_q[i] <= '0;
            sum_q   <= '0;
            st_q    <= TEMP_RST;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            for (int i = 0; i < 4; i++) w_q[i] <= w_d[i];
            sum_q   <= sum_d;
            st_q    <= st_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        for (int i = 0; i < 4; i++) w_d[i] = w_q[i];
        sum_d   = sum_q;
        st_d    = st_q;
        fault_d = fault_q;
        if (adc_valid) begin
            if (adc_temp > TEMP_MAX) begin
                fault_d = 1'b1;
            end else begin
                fault_d = 1'b0;
                if (state_q == T_EMPTY) begin
                    // First sample fills the whole window so the average starts at that value.
                    for (int i = 0; i < 4; i++) w_d[i] = adc_temp;
                    sum_d   = {adc_temp, 2'b00};
                    state_d = T_RUN;
                end else begin
                    w_d[0] = adc_temp;
                    w_d[1] = w_q[0];
                    w_d[2] = w_q[1];
                    w_d[3] = w_q[2];
                    sum_d  = sum_q + SUM_W'(adc_temp) - SUM_W'(w_q[3]);
                end
                st_d = sum_d[SUM_W-1:2];
            end
        end
    end

    assign ST         = st_q;
    assign temp_fault = fault_q;

endmodule

// File: tb/tb_sensor_conditioner.sv
// tb/tb_sensor_conditioner.sv - scoreboard bench for sensor_conditioner
module tb_sensor_conditioner;

    localparam int DEB = 4;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       raw_fd, raw_rd, raw_w, raw_fa;
    logic [6:0] adc_temp;
    logic       adc_valid;
    logic       SFD, SRD, SW, SFA;
    logic [6:0] ST;
    logic       temp_fault;

    always #5 Clk = ~Clk;

    sensor_conditioner #(.DEB_CYCLES(DEB)) dut (
        .Clk(Clk), .Rst(Rst),
        .raw_fd(raw_fd), .raw_rd(raw_rd), .raw_w(raw_w), .raw_fa(raw_fa),
        .adc_temp(adc_temp), .adc_valid(adc_valid),
        .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA),
        .ST(ST), .temp_fault(temp_fault)
    );

    typedef struct {
        int bits;
        int st;
        int fault;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [15:0] hist [4];
    logic [3:0]  m_out;
    int          win[$];
    int          m_st;
    int          m_fault;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // A binary output flips once the last DEB synchronised samples (seen two edges late)
    // all disagree with it; the alarm channel also rises on the first synchronised 1.
    function automatic void model_edge(input bit rst, input logic [3:0] raw, input bit v, input int t);
        bit all_diff;
        int sum;
        if (rst) begin
            for (int c = 0; c < 4; c++) hist[c] = '0;
            m_out = '0;
            win.delete();
            m_st = 25;
            m_fault = 0;
            return;
        end
        for (int c = 0; c < 4; c++) begin
            hist[c] = {hist[c][14:0], raw[c]};
            all_diff = 1'b1;
            for (int k = 2; k <= DEB + 1; k++)
                if (hist[c][k] == m_out[c]) all_diff = 1'b0;
            if (c == 3 && hist[c][2] && !m_out[c]) m_out[c] = 1'b1;
            else if (all_diff) m_out[c] = ~m_out[c];
        end
        if (v) begin
            if (t > 100) begin
                m_fault = 1;
            end else begin
                m_fault = 0;
                if (win.size() == 0) begin
                    repeat (4) win.push_back(t);
                end else begin
                    win.push_back(t);
                    void'(win.pop_front());
                end
                sum = 0;
                foreach (win[i]) sum += win[i];
                m_st = sum / 4;
            end
        end
    endfunction

    task automatic step(input bit rst, input logic [3:0] raw, input bit v, input int t);
        exp_t e;
        Rst       = rst;
        raw_fd    = raw[0];
        raw_rd    = raw[1];
        raw_w     = raw[2];
        raw_fa    = raw[3];
        adc_valid = v;
        adc_temp  = 7'(t);
        @(posedge Clk);
        #1;
        model_edge(rst, raw, v, t);
        e.bits  = int'(m_out);
        e.st    = m_st;
        e.fault = m_fault;
        exp_q.push_back(e);
    endtask

    exp_t mon_e;
    always @(negedge Clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_sensors", int'({SFA, SW, SRD, SFD}), mon_e.bits);
            chk("sb_st", int'(ST), mon_e.st);
            chk("sb_fault", int'(temp_fault), mon_e.fault);
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    logic [3:0] r;
    int         samp [4];
    int         avg  [4];
    int         saw;
    bit         rrst, rv;

    initial begin
        samp = '{40, 44, 48, 52};
        avg  = '{40, 41, 43, 46};

        step(1, 4'hF, 1, 60);
        step(1, 4'hF, 1, 60);
        chk("rst_bits", int'({SFA, SW, SRD, SFD}), 0);
        chk("rst_st", int'(ST), 25);
        chk("rst_fault", int'(temp_fault), 0);
        step(0, 4'h0, 0, 0);
        chk("rel_bits", int'({SFA, SW, SRD, SFD}), 0);
        chk("rel_st", int'(ST), 25);
        repeat (6) step(0, 4'h0, 0, 0);

        for (int i = 1; i <= 6; i++) begin
            step(0, 4'b0001, 0, 0);
            if (i == 5) chk("fd_edge5", int'(SFD), 0);
            if (i == 6) chk("fd_edge6", int'(SFD), 1);
        end

        repeat (3) step(0, 4'b0011, 0, 0);
        repeat (8) begin
            step(0, 4'b0001, 0, 0);
            chk("rd_glitch3", int'(SRD), 0);
        end
        saw = 0;
        repeat (4) step(0, 4'b0011, 0, 0);
        repeat (12) begin
            step(0, 4'b0001, 0, 0);
            if (SRD) saw = 1;
        end
        chk("rd_glitch4_pulse", saw, 1);
        chk("rd_glitch4_end", int'(SRD), 0);

        for (int i = 1; i <= 3; i++) begin
            step(0, 4'b1001, 0, 0);
            if (i == 2) chk("fa_edge2", int'(SFA), 0);
            if (i == 3) chk("fa_edge3", int'(SFA), 1);
        end
        repeat (3) step(0, 4'b1001, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            step(0, 4'b0001, 0, 0);
            if (i == 5) chk("fa_fall5", int'(SFA), 1);
            if (i == 6) chk("fa_fall6", int'(SFA), 0);
        end
        repeat (6) step(0, 4'b1001, 0, 0);
        repeat (2) step(0, 4'b0001, 0, 0);
        repeat (8) begin
            step(0, 4'b1001, 0, 0);
            chk("fa_short_drop", int'(SFA), 1);
        end
        repeat (8) step(0, 4'b0001, 0, 0);

        for (int i = 0; i < 4; i++) begin
            step(0, 4'b0001, 1, samp[i]);
            chk("avg_st", int'(ST), avg[i]);
            step(0, 4'b0001, 0, 0);
        end

        step(0, 4'b0001, 1, 110);
        chk("fault_st_hold", int'(ST), 46);
        chk("fault_set", int'(temp_fault), 1);
        step(0, 4'b0001, 0, 0);
        chk("fault_sticky", int'(temp_fault), 1);
        step(0, 4'b0001, 1, 30);
        chk("fault_clear", int'(temp_fault), 0);
        chk("fault_next_st", int'(ST), 43);

        repeat (8) step(0, 4'b0000, 0, 0);
        repeat (5) step(0, 4'b0001, 0, 0);
        step(1, 4'b0001, 0, 0);
        chk("midrst_sfd", int'(SFD), 0);
        chk("midrst_st", int'(ST), 25);
        step(0, 4'b0000, 1, 70);
        chk("midrst_preload", int'(ST), 70);
        repeat (8) begin
            step(0, 4'b0000, 0, 0);
            chk("midrst_sfd_quiet", int'(SFD), 0);
        end

        r = 4'b0000;
        repeat (3000) begin
            for (int c = 0; c < 4; c++)
                if ($urandom_range(0, 3) == 0) r[c] = ~r[c];
            rrst = ($urandom_range(0, 299) == 0);
            rv   = ($urandom_range(0, 2) == 0);
            step(rrst, r, rv, int'($urandom_range(0, 127)));
        end

        @(negedge Clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
